// File: rtl/mcu_pkg.sv
// mcu_pkg: shared register map, FSM state encoding and CTRL/STATUS field positions
package mcu_pkg;
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_STATUS   = 2'd1;
   localparam logic [1:0] REG_INSTR_LO = 2'd2;
   localparam logic [1:0] REG_INSTR_HI = 2'd3;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1, ST_COMMIT = 2'd2} state_t;
   function automatic int ctrl_sel_lsb(input int pc_w);
      return pc_w;
   endfunction
   function automatic int ctrl_halt_lsb(input int pc_w, input int log_c);
      return pc_w + log_c;
   endfunction
   function automatic int stat_busy_bit(input int pc_w);
      return pc_w;
   endfunction
   function automatic int stat_wrap_bit(input int pc_w);
      return pc_w + 1;
   endfunction
endpackage

// File: rtl/prog_stage.sv
// prog_stage: instruction stage register, programming pointer and sticky wrap flag
module prog_stage import mcu_pkg::*; #(
   parameter int PC_WIDTH    = 6,
   parameter int INSTR_DEPTH = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int WB_WIDTH    = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   lo_we_i,
   input  logic                   hi_we_i,
   input  logic                   ctrl_we_i,
   input  logic                   wrap_clr_i,
   input  logic                   adv_i,
   input  logic [WB_WIDTH-1:0]    wdat_i,
   input  logic [PC_WIDTH-1:0]    ptr_wr_i,
   output logic [INSTR_WIDTH-1:0] stage_o,
   output logic [PC_WIDTH-1:0]    ptr_o,
   output logic                   wrap_o
);
   localparam logic [PC_WIDTH-1:0] LAST = PC_WIDTH'(INSTR_DEPTH - 1);
   logic [INSTR_WIDTH-1:0] stage_q, stage_d;
   logic [PC_WIDTH-1:0] ptr_q, ptr_d;
   logic wrap_q, wrap_d, unused_in;
   assign unused_in = ^{wdat_i, hi_we_i};
   generate
      if (INSTR_WIDTH > WB_WIDTH) begin : g_hi
         assign stage_d = hi_we_i ? {wdat_i[INSTR_WIDTH-WB_WIDTH-1:0], stage_q[WB_WIDTH-1:0]}
                        : lo_we_i ? {stage_q[INSTR_WIDTH-1:WB_WIDTH], wdat_i} : stage_q;
      end else begin : g_lo
         assign stage_d = lo_we_i ? wdat_i[INSTR_WIDTH-1:0] : stage_q;
      end
   endgenerate
   // a CTRL write always beats an advance; out-of-range pointers clamp to the last word
   assign ptr_d = ctrl_we_i ? ((int'(ptr_wr_i) >= INSTR_DEPTH) ? LAST : ptr_wr_i)
                : adv_i ? ((ptr_q == LAST) ? '0 : ptr_q + 1'b1) : ptr_q;
   assign wrap_d = wrap_clr_i ? 1'b0 : (adv_i && !ctrl_we_i && ptr_q == LAST) ? 1'b1 : wrap_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         stage_q <= '0;
         ptr_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         stage_q <= stage_d;
         ptr_q   <= ptr_d;
         wrap_q  <= wrap_d;
      end
   assign stage_o = stage_q;
   assign ptr_o   = ptr_q;
   assign wrap_o  = wrap_q;
endmodule

// File: rtl/wb_prog_bridge.sv
// wb_prog_bridge: Wishbone slave that stages instruction words and writes them
// into per-core instruction memories through a ready/valid programming port
module wb_prog_bridge import mcu_pkg::*; #(
   parameter int CORES       = 4,
   parameter int LOG_CORES   = 2,
   parameter int PC_WIDTH    = 6,
   parameter int INSTR_DEPTH = 16,
   parameter int INSTR_WIDTH = 32,
   parameter int WB_WIDTH    = 32
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [WB_WIDTH-1:0]    wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [WB_WIDTH-1:0]    wbs_dat_o,
   output logic                   prog_we,
   input  logic                   prog_ready,
   output logic [LOG_CORES-1:0]   prog_core,
   output logic [PC_WIDTH-1:0]    prog_addr,
   output logic [INSTR_WIDTH-1:0] prog_data,
   output logic [CORES-1:0]       core_halt
);
   localparam int SEL_LSB  = ctrl_sel_lsb(PC_WIDTH);
   localparam int HALT_LSB = ctrl_halt_lsb(PC_WIDTH, LOG_CORES);
   localparam int BUSY_BIT = stat_busy_bit(PC_WIDTH);
   localparam int WRAP_BIT = stat_wrap_bit(PC_WIDTH);
   localparam logic [1:0] COMMIT_REG = (INSTR_WIDTH > WB_WIDTH) ? REG_INSTR_HI : REG_INSTR_LO;
   state_t state_q;
   logic ack_q, prog_we_q, abort_q;
   logic [WB_WIDTH-1:0] dat_q, rdata;
   logic [CORES-1:0] halt_q;
   logic [LOG_CORES-1:0] sel_q;
   logic [PC_WIDTH-1:0] ptr;
   logic [1:0] rsel;
   logic wrap, req, wr, commit, adv, keep, unused_adr;
   assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};
   assign rsel   = wbs_adr_i[3:2];
   assign req    = state_q == ST_IDLE && wbs_stb_i && wbs_cyc_i;
   assign wr     = req && wbs_we_i;
   assign commit = wr && rsel == COMMIT_REG;
   assign adv    = state_q == ST_COMMIT && prog_ready;
   assign keep   = wbs_cyc_i && !abort_q;
   always_comb begin
      rdata = '0;
      if (rsel == REG_CTRL) begin
         rdata[PC_WIDTH-1:0]         = ptr;
         rdata[SEL_LSB +: LOG_CORES] = sel_q;
         rdata[HALT_LSB +: CORES]    = halt_q;
      end else if (rsel == REG_STATUS) begin
         rdata[PC_WIDTH-1:0] = ptr;
         rdata[BUSY_BIT]     = state_q == ST_COMMIT;
         rdata[WRAP_BIT]     = wrap;
      end
   end
   prog_stage #(
      .PC_WIDTH(PC_WIDTH), .INSTR_DEPTH(INSTR_DEPTH),
      .INSTR_WIDTH(INSTR_WIDTH), .WB_WIDTH(WB_WIDTH)
   ) u_stage (
      .clk_i(wb_clk_i),
      .rst_i(wb_rst_i),
      .lo_we_i(wr && rsel == REG_INSTR_LO),
      .hi_we_i(wr && rsel == REG_INSTR_HI),
      .ctrl_we_i(wr && rsel == REG_CTRL),
      .wrap_clr_i(wr && rsel == REG_STATUS),
      .adv_i(adv),
      .wdat_i(wbs_dat_i),
      .ptr_wr_i(wbs_dat_i[PC_WIDTH-1:0]),
      .stage_o(prog_data),
      .ptr_o(ptr),
      .wrap_o(wrap)
   );
   // a master that drops cyc mid-commit still gets its word written, just never acked
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         prog_we_q <= 1'b0;
         abort_q   <= 1'b0;
         halt_q    <= '1;
         sel_q     <= '0;
      end else begin
         ack_q <= 1'b0;
         dat_q <= '0;
         case (state_q)
            ST_IDLE: if (req) begin
               if (wr && rsel == REG_CTRL) begin
                  halt_q <= wbs_dat_i[HALT_LSB +: CORES];
                  sel_q  <= wbs_dat_i[SEL_LSB +: LOG_CORES];
               end
               state_q   <= commit ? ST_COMMIT : ST_ACK;
               ack_q     <= !commit;
               dat_q     <= wbs_we_i ? '0 : rdata;
               prog_we_q <= commit && int'(sel_q) < CORES;
               abort_q   <= 1'b0;
            end
            ST_COMMIT: if (adv) begin
               state_q   <= keep ? ST_ACK : ST_IDLE;
               ack_q     <= keep;
               prog_we_q <= 1'b0;
            end else if (!wbs_cyc_i) abort_q <= 1'b1;
            default: state_q <= ST_IDLE;
         endcase
      end
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign prog_we   = prog_we_q;
   assign prog_core = sel_q;
   assign prog_addr = ptr;
   assign core_halt = halt_q;
endmodule

// File: tb/tb_wb_prog_bridge.sv
// tb_wb_prog_bridge: randomized bench checking two bridges (32- and 48-bit
// instructions) against a transaction-level model of the register map
module tb_wb_prog_bridge;
   logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0, tgt = 0, prog_ready = 0, rdy_rand = 0;
   logic [31:0] adr = 0, wdat = 0;
   logic ack_a, ack_b, pwe_a, pwe_b;
   logic [31:0] dat_a, dat_b, pdata_a;
   logic [47:0] pdata_b;
   logic [1:0] pcore_a, pcore_b;
   logic [5:0] paddr_a, paddr_b;
   logic [3:0] halt_a, halt_b;
   logic [55:0] last_b = 0;
   logic ack_prev = 0;
   logic [39:0] q[$];
   logic [3:0] m_halt;
   logic [1:0] m_sel;
   logic [5:0] m_ptr;
   logic m_wrap;
   int vectors = 0, miscompares = 0, pwe_cnt_a = 0, pwe_cnt_b = 0;

   always #5 clk = ~clk;

   wb_prog_bridge u_a (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb && !tgt), .wbs_cyc_i(cyc && !tgt), .wbs_we_i(we),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
      .prog_we(pwe_a), .prog_ready(prog_ready), .prog_core(pcore_a),
      .prog_addr(paddr_a), .prog_data(pdata_a), .core_halt(halt_a)
   );

   wb_prog_bridge #(.INSTR_WIDTH(48)) u_b (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb && tgt), .wbs_cyc_i(cyc && tgt), .wbs_we_i(we),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
      .prog_we(pwe_b), .prog_ready(prog_ready), .prog_core(pcore_b),
      .prog_addr(paddr_b), .prog_data(pdata_b), .core_halt(halt_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [1:0] r, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
      logic [31:0] a;
      a = $urandom();
      a[3:2] = r;
      @(posedge clk);
      #1;
      stb = 1; cyc = 1; we = w; adr = a; wdat = d;
      rd = '0;
      lat = 0;
      for (int n = 1; n <= 200 && lat == 0; n++) begin
         @(negedge clk);
         if (tgt ? ack_b : ack_a) begin
            lat = n;
            rd = tgt ? dat_b : dat_a;
         end
      end
      check("ack_seen", lat != 0, 1);
      @(posedge clk);
      #1;
      stb = 0; cyc = 0; we = 0;
   endtask

   task automatic model_reset();
      m_halt = '1; m_sel = 0; m_ptr = 0; m_wrap = 0;
      q.delete();
   endtask

   task automatic op(input logic w, input logic [1:0] r, input logic [31:0] d);
      logic [31:0] rd, exp;
      int lat;
      exp = '0;
      if (!w && r == 0) exp = {20'd0, m_halt, m_sel, m_ptr};
      if (!w && r == 1) exp = {24'd0, m_wrap, 1'b0, m_ptr};
      if (w && r == 2) q.push_back({m_sel, m_ptr, d});
      bus(w, r, d, rd, lat);
      check(w ? "wr_data" : "rd_data", rd, exp);
      check("latency", (w && r == 2) ? lat >= 3 : lat == 2, 1);
      if (w && r == 0) begin
         m_halt = d[11:8];
         m_sel  = d[7:6];
         m_ptr  = (d[5:0] > 15) ? 6'd15 : d[5:0];
      end
      if (w && r == 1) m_wrap = 0;
      if (w && r == 2) begin
         m_wrap = m_wrap | (m_ptr == 15);
         m_ptr  = 6'((m_ptr + 1) % 16);
      end
      check("core_halt", halt_a, m_halt);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) prog_ready = $urandom_range(0, 3) != 0;
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (!ack_a) check("dat_idle", dat_a, 0);
         if (ack_a) check("ack_needs_cyc", cyc && !tgt, 1);
         if (ack_b) check("b_ack_needs_cyc", cyc && tgt, 1);
         check("ack_pulse", ack_a && ack_prev, 0);
         if (pwe_a) begin
            pwe_cnt_a++;
            check("we_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               check("prog_cmd", {pcore_a, paddr_a, pdata_a}, q[0]);
               if (prog_ready) void'(q.pop_front());
            end
         end
         if (pwe_b) begin
            pwe_cnt_b++;
            last_b = {pcore_b, paddr_b, pdata_b};
         end
      end
      ack_prev = ack_a && !rst;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int lat, c0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      bus(0, 0, 0, rd, lat);
      check("ctrl_reset", rd, 32'h0000_0F00);
      check("reg_latency", lat, 2);
      bus(0, 1, 0, rd, lat);
      check("status_reset", rd, 0);
      prog_ready = 1;
      op(1, 0, 32'h0000_0F85);
      q.push_back({2'd2, 6'd5, 32'hDEADBEEF});
      c0 = pwe_cnt_a;
      bus(1, 2, 32'hDEADBEEF, rd, lat);
      check("commit_lat", lat, 3);
      check("we_pulses", pwe_cnt_a - c0, 1);
      m_ptr = 6;
      bus(0, 1, 0, rd, lat);
      check("status_ptr6", rd, 32'h6);
      prog_ready = 0;
      c0 = pwe_cnt_a;
      q.push_back({2'd2, 6'd6, 32'hCAFEF00D});
      fork
         bus(1, 2, 32'hCAFEF00D, rd, lat);
         begin
            @(posedge clk);
            repeat (8) @(posedge clk);
            #1 prog_ready = 1;
         end
      join
      check("stall_lat", lat, 10);
      check("stall_we_cycles", pwe_cnt_a - c0, 8);
      m_ptr = 7;
      op(1, 0, {20'd0, 4'hF, 2'd1, 6'd40});
      bus(0, 0, 0, rd, lat);
      check("ctrl_clamp", rd, 32'h0000_0F4F);
      op(1, 0, 32'h0000_0F0F);
      op(1, 2, 32'h12345678);
      bus(0, 1, 0, rd, lat);
      check("status_wrap", rd, 32'h80);
      op(1, 1, 0);
      bus(0, 1, 0, rd, lat);
      check("wrap_cleared", rd, 0);
      prog_ready = 0;
      q.push_back({m_sel, m_ptr, 32'hA5A5A5A5});
      @(posedge clk);
      #1 stb = 1; cyc = 1; we = 1; adr = 32'h8; wdat = 32'hA5A5A5A5;
      @(posedge clk);
      #1 stb = 0; cyc = 0; we = 0;
      repeat (3) @(posedge clk);
      #1 prog_ready = 1;
      repeat (6) @(posedge clk);
      #1;
      check("drop_drained", q.size(), 0);
      m_ptr = 6'((m_ptr + 1) % 16);
      op(0, 1, 0);
      rdy_rand = 1;
      for (int i = 0; i < 300; i++) begin
         int k;
         k = $urandom_range(0, 7);
         case (k)
            0: op(1, 0, $urandom());
            1: op(0, 0, 0);
            2: op(0, 1, 0);
            3: op(1, 1, 0);
            7: op(1, 3, $urandom());
            default: op(1, 2, $urandom());
         endcase
      end
      rdy_rand = 0;
      @(posedge clk);
      #2 prog_ready = 0;
      q.push_back({m_sel, m_ptr, 32'h0BADF00D});
      @(posedge clk);
      #1 stb = 1; cyc = 1; we = 1; adr = 32'h8; wdat = 32'h0BADF00D;
      @(posedge clk);
      @(negedge clk);
      check("we_before_rst", pwe_a, 1);
      #1 rst = 1;
      #1;
      check("we_in_rst", pwe_a, 0);
      check("ack_in_rst", ack_a, 0);
      check("halt_in_rst", halt_a, 4'hF);
      check("prog_rst", {pcore_a, paddr_a, pdata_a}, 0);
      stb = 0; cyc = 0; we = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      prog_ready = 1;
      c0 = pwe_cnt_a;
      repeat (6) @(posedge clk);
      #1;
      check("no_we_after_rst", pwe_cnt_a - c0, 0);
      bus(0, 0, 0, rd, lat);
      check("ctrl_after_rst", rd, 32'h0000_0F00);
      bus(0, 1, 0, rd, lat);
      check("status_after_rst", rd, 0);
      tgt = 1;
      check("b_halt", halt_b, 4'hF);
      c0 = pwe_cnt_b;
      bus(1, 2, 32'h11223344, rd, lat);
      check("b_lo_lat", lat, 2);
      check("b_lo_no_commit", pwe_cnt_b - c0, 0);
      bus(1, 3, 32'h00005566, rd, lat);
      check("b_hi_lat", lat, 3);
      check("b_commit_cnt", pwe_cnt_b - c0, 1);
      check("b_commit", last_b, {2'd0, 6'd0, 48'h556611223344});
      bus(0, 1, 0, rd, lat);
      check("b_status", rd, 32'h1);
      tgt = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
